// File: rtl/debounce_pkg.sv
// Shared definitions for the switch debouncer: per-channel state encoding and
// the default stability window.
package debounce_pkg;

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_CHANGING = 1'b1
  } ch_state_e;

  // 10 ms at 100 MHz.
  localparam int unsigned DEFAULT_STABLE_CYCLES = 1000000;

endpackage

// File: rtl/debounce_channel.sv
// One debounced switch channel: two-flop synchronizer, stability counter FSM
// and registered rise/fall pulses.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sw,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  localparam int unsigned CNT_WIDTH = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);

  if (STABLE_CYCLES < 2) begin : g_bad_param
    $error("debounce_channel: STABLE_CYCLES must be at least 2");
  end

  logic                 r_s1;
  logic                 r_s2;
  ch_state_e            r_state;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_level;
  logic                 r_rise;
  logic                 r_fall;

  logic                 w_differ;
  logic                 w_cnt_done;

  assign w_differ   = (r_s2 != r_level);
  assign w_cnt_done = (r_cnt == CNT_LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_state <= ST_STABLE;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_s1   <= i_sw;
      r_s2   <= r_s1;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      unique case (r_state)
        ST_STABLE: begin
          if (w_differ) begin
            r_state <= ST_CHANGING;
            r_cnt   <= CNT_ONE;
          end
        end
        ST_CHANGING: begin
          if (!w_differ) begin
            // Any return to agreement discards the partial count.
            r_state <= ST_STABLE;
            r_cnt   <= '0;
          end else if (w_cnt_done) begin
            r_level <= r_s2;
            r_rise  <= r_s2;
            r_fall  <= ~r_s2;
            r_state <= ST_STABLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
      endcase
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/switch_debounce_2ch.sv
// Two independent debounced switch channels feeding the gate block's A/B
// inputs; bit0 is channel A, bit1 is channel B.
module switch_debounce_2ch
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic [1:0] iSw,
  output logic [1:0] oLevel,
  output logic [1:0] oRise,
  output logic [1:0] oFall
);

  for (genvar g = 0; g < 2; g++) begin : g_ch
    debounce_channel #(
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_channel (
      .i_clk  (iClk),
      .i_rst  (iRst),
      .i_sw   (iSw[g]),
      .o_level(oLevel[g]),
      .o_rise (oRise[g]),
      .o_fall (oFall[g])
    );
  end

endmodule

// File: tb/tb_switch_debounce_2ch.sv
// Bench for switch_debounce_2ch: directed scenarios plus random switch activity,
// all cycles compared against a sample-window reference model.
module tb_switch_debounce_2ch;

  localparam int NS = 4;

  logic       iClk = 1'b0;
  logic       iRst = 1'b1;
  logic [1:0] iSw  = 2'b00;
  logic [1:0] oLevel;
  logic [1:0] oRise;
  logic [1:0] oFall;

  switch_debounce_2ch #(
    .STABLE_CYCLES(NS)
  ) dut (
    .iClk  (iClk),
    .iRst  (iRst),
    .iSw   (iSw),
    .oLevel(oLevel),
    .oRise (oRise),
    .oFall (oFall)
  );

  always #5 iClk = ~iClk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a level flips once the last NS synchronized samples,
  // all taken after the previous flip or reset, disagree with it.
  logic [1:0] sw_hist[$];
  logic [1:0] s2_hist[$];
  logic [1:0] m_level = 2'b00;
  logic [1:0] m_rise  = 2'b00;
  logic [1:0] m_fall  = 2'b00;
  int         m_last[2] = '{-1, -1};

  task automatic m_step(input logic [1:0] sw, input logic rst);
    logic [1:0] s2;
    int         idx;
    bit         all;
    if (rst) begin
      sw_hist.delete();
      s2_hist.delete();
      m_level   = 2'b00;
      m_rise    = 2'b00;
      m_fall    = 2'b00;
      m_last[0] = -1;
      m_last[1] = -1;
    end else begin
      s2 = (sw_hist.size() >= 2) ? sw_hist[sw_hist.size()-2] : 2'b00;
      sw_hist.push_back(sw);
      s2_hist.push_back(s2);
      idx    = s2_hist.size() - 1;
      m_rise = 2'b00;
      m_fall = 2'b00;
      for (int ch = 0; ch < 2; ch++) begin
        if (idx - m_last[ch] >= NS) begin
          all = 1'b1;
          for (int j = 0; j < NS; j++) begin
            if (s2_hist[idx-j][ch] == m_level[ch]) all = 1'b0;
          end
          if (all) begin
            m_level[ch] = ~m_level[ch];
            if (m_level[ch]) m_rise[ch] = 1'b1;
            else m_fall[ch] = 1'b1;
            m_last[ch] = idx;
          end
        end
      end
    end
  endtask

  int rise_cnt[2];
  int fall_cnt[2];
  bit seen_rise11;
  bit seen_fall11;

  task automatic clr_cnt();
    rise_cnt    = '{0, 0};
    fall_cnt    = '{0, 0};
    seen_rise11 = 1'b0;
    seen_fall11 = 1'b0;
  endtask

  task automatic tick(input logic [1:0] sw, input logic rst);
    @(negedge iClk);
    iSw  = sw;
    iRst = rst;
    @(posedge iClk);
    m_step(sw, rst);
    #1;
    check_eq("model", {26'd0, oLevel, oRise, oFall}, {26'd0, m_level, m_rise, m_fall});
    for (int ch = 0; ch < 2; ch++) begin
      if (oRise[ch]) rise_cnt[ch]++;
      if (oFall[ch]) fall_cnt[ch]++;
    end
    if (oRise == 2'b11) seen_rise11 = 1'b1;
    if (oFall == 2'b11) seen_fall11 = 1'b1;
  endtask

  // Holds sw and counts edges until oLevel[ch] == val, bounded by limit.
  task automatic run_until(input logic [1:0] sw, input int ch, input logic val,
                           input int limit, output int n);
    n = 0;
    do begin
      tick(sw, 1'b0);
      n++;
    end while (oLevel[ch] !== val && n < limit);
  endtask

  task automatic hold(input logic [1:0] sw, input int cycles);
    for (int i = 0; i < cycles; i++) tick(sw, 1'b0);
  endtask

  int lat;

  initial begin
    clr_cnt();
    // Reset with both switches high.
    for (int i = 0; i < 3; i++) begin
      tick(2'b11, 1'b1);
      check_eq("rst_out", {26'd0, oLevel, oRise, oFall}, 32'd0);
    end
    run_until(2'b11, 0, 1'b1, 20, lat);
    check_eq("rst_lat", lat, 6);
    check_eq("rst_rise", {30'd0, oRise}, 32'h3);
    check_eq("rst_level", {30'd0, oLevel}, 32'h3);
    tick(2'b11, 1'b0);
    check_eq("rst_rise_once", {30'd0, oRise}, 32'h0);

    // Back to 00, then clean step on channel A.
    hold(2'b00, 8);
    clr_cnt();
    run_until(2'b01, 0, 1'b1, 20, lat);
    check_eq("step_lat", lat, 6);
    hold(2'b01, 4);
    check_eq("step_rise_cnt", rise_cnt[0], 1);
    check_eq("step_b_quiet", rise_cnt[1] + fall_cnt[1] + fall_cnt[0], 0);
    check_eq("step_b_level", {31'd0, oLevel[1]}, 32'd0);
    hold(2'b00, 8);

    // Glitch of NS-1 samples is rejected.
    clr_cnt();
    hold(2'b01, NS - 1);
    hold(2'b00, 10);
    check_eq("glitch3_pulses", rise_cnt[0] + fall_cnt[0], 0);
    check_eq("glitch3_level", {31'd0, oLevel[0]}, 32'd0);

    // Glitch of exactly NS samples is accepted, then undone.
    clr_cnt();
    hold(2'b01, NS);
    hold(2'b00, 12);
    check_eq("glitch4_rise", rise_cnt[0], 1);
    check_eq("glitch4_fall", fall_cnt[0], 1);
    check_eq("glitch4_level", {31'd0, oLevel[0]}, 32'd0);

    // Bounce on channel B, ending low, then held high.
    clr_cnt();
    for (int i = 0; i < 10; i++) tick((i % 2 == 0) ? 2'b10 : 2'b00, 1'b0);
    run_until(2'b10, 1, 1'b1, 20, lat);
    check_eq("bounce_lat", lat, 6);
    hold(2'b10, 6);
    check_eq("bounce_rise", rise_cnt[1], 1);
    check_eq("bounce_fall", fall_cnt[1], 0);
    hold(2'b00, 8);

    // Simultaneous rise and fall on both channels.
    clr_cnt();
    hold(2'b11, 8);
    check_eq("sim_rise11", {31'd0, seen_rise11}, 32'd1);
    hold(2'b00, 8);
    check_eq("sim_fall11", {31'd0, seen_fall11}, 32'd1);
    check_eq("sim_counts", rise_cnt[0] + rise_cnt[1] + fall_cnt[0] + fall_cnt[1], 4);

    // Reset in the middle of a count.
    clr_cnt();
    hold(2'b01, 4);
    tick(2'b01, 1'b1);
    check_eq("midrst_level", {30'd0, oLevel}, 32'd0);
    run_until(2'b01, 0, 1'b1, 20, lat);
    check_eq("midrst_lat", lat, 6);
    hold(2'b01, 4);
    check_eq("midrst_rise", rise_cnt[0], 1);
    hold(2'b00, 8);

    // Random switch activity with occasional resets.
    for (int seg = 0; seg < 400; seg++) begin
      logic [1:0] sw;
      int         len;
      sw  = 2'($urandom_range(0, 3));
      len = $urandom_range(1, 8);
      tick(sw, ($urandom_range(0, 39) == 0));
      hold(sw, len - 1);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/switch_debounce_2ch.md
Name: switch_debounce_2ch

Overview:
- Input-conditioning stage that sits directly upstream of the two-input gate block.
- Takes two raw, asynchronous, bouncing board switches and produces clean, synchronized levels that drive the gate block's A/B inputs.
- Also emits one-cycle rise/fall pulses for each channel.
- One clock domain; all outputs are registered.

Parameters:
- STABLE_CYCLES, 1000000 — consecutive disagreeing cycles required before a level is accepted; must be ≥ 2 (10 ms at 100 MHz).
- CNT_WIDTH, derived localparam = $clog2(STABLE_CYCLES+1) — counter width; not overridable.

Ports:
- iClk  input  1  system clock, rising edge.
- iRst  input  1  synchronous reset, active-high.
- iSw  input  2  raw switch levels, asynchronous; bit0 = channel A, bit1 = channel B.
- oLevel  output  2  debounced level per channel; bit0 feeds gate input A, bit1 feeds gate input B.
- oRise  output  2  one-cycle pulse when oLevel[n] goes 0→1.
- oFall  output  2  one-cycle pulse when oLevel[n] goes 1→0.

Behaviour:
- Reset: while iRst is high at a rising edge, the following clear to 0:
  - sync flops, counters, oLevel, oRise, oFall;
  - per-channel state goes to STABLE.
  - Reset has priority over every other event.
- Synchronizer: two flops per channel (s1 ← iSw[n], s2 ← s1); there is no combinational path from iSw to any output.
- Per-channel FSM (channels fully independent), "differ" meaning s2 ≠ oLevel[n]:
  - STABLE, cnt = 0: if s2 ≠ oLevel[n] → CHANGING, cnt ← 1; else stay.
  - CHANGING, s2 == oLevel[n]: glitch rejected → STABLE, cnt ← 0, no output change.
  - CHANGING, s2 ≠ oLevel[n], cnt == STABLE_CYCLES−1: at this edge oLevel[n] ← s2, pulse set, → STABLE, cnt ← 0.
  - CHANGING, s2 ≠ oLevel[n], otherwise: cnt ← cnt+1.
- Latency: a new iSw value first sampled at edge k (held steady) appears on oLevel after edge k+STABLE_CYCLES+1.
- Acceptance threshold:
  - a raw pulse sampled by fewer than STABLE_CYCLES edges never reaches oLevel;
  - a raw pulse sampled by exactly STABLE_CYCLES edges is accepted.
- Pulses:
  - oRise[n] / oFall[n] are high for exactly the one cycle in which oLevel[n] holds its newly updated value; low otherwise.
  - At most one of oRise[n] / oFall[n] is high per channel per cycle.
- Bounce: any return to agreement restarts the count from 0, so a bounce burst yields at most one level change and one pulse after settling.
- Simultaneous events: both channels may update in the same cycle, e.g. oRise = 2'b11.
- Counter: never exceeds STABLE_CYCLES−1; no wrap-around is possible.
- Reset mid-count: the partial count is discarded and oLevel is forced to 0. If the switch is still high after reset release, a normal rise occurs STABLE_CYCLES+2 edges after release, including the rise pulse.

Decomposition:
- Shared package/header debounce_pkg holds:
  - channel state encoding (ST_STABLE = 1'b0, ST_CHANGING = 1'b1);
  - DEFAULT_STABLE_CYCLES = 1000000.
- One natural sub-module, debounce_channel (synchronizer + FSM + counter + pulse regs for one bit), instantiated twice by switch_debounce_2ch.

Test Plan (STABLE_CYCLES = 4):
- Reset: iSw = 2'b11, iRst high for 3 edges → oLevel / oRise / oFall = 0 throughout; after release, oLevel = 2'b11 after edge 6 post-release, with oRise = 2'b11 for that single cycle.
- Clean step: iSw[0] 0→1 first sampled at edge k → oLevel[0] = 1 after edge k+5, oRise[0] = 1 for exactly one cycle; bit1 outputs stay 0.
- Glitch boundary: iSw[0] high for 3 sample edges then low → no oLevel or pulse change. Repeat with 4 sample edges → oLevel[0] rises, then falls 4 cycles later, with one oRise and one oFall.
- Bounce: iSw[1] toggles every cycle for 10 cycles, then holds 1 from edge k → exactly one oRise[1], oLevel[1] = 1 after edge k+5, no oFall.
- Simultaneous: iSw 2'b00→2'b11 at the same edge → oRise = 2'b11 in one cycle. Later 2'b11→2'b00 → oFall = 2'b11 in one cycle.
- Reset mid-count: iSw[0] = 1 held; after 2 CHANGING cycles assert iRst for 1 edge → oLevel[0] = 0, counter cleared. oLevel[0] then rises 6 edges after release with a single oRise[0].
